// File: rtl/vector_alu_issue.sv
// Issue/collect controller: registers one request into the vector ALU, waits ALU_LAT cycles,
// captures the result into a response FIFO. Optional per-lane zero flags under LANE_ZERO_EN.
module vector_alu_issue #(
    parameter int unsigned RESP_DEPTH = 2,
    parameter int unsigned ALU_LAT    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_a,
    input  logic [127:0] req_b,
    input  logic [2:0]   req_ctrl,
    input  logic         req_vec,
    output logic [127:0] alu_a,
    output logic [127:0] alu_b,
    output logic [2:0]   alu_ctrl,
    output logic         alu_vec,
    input  logic [127:0] alu_result,
    input  logic         alu_zero,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_result,
    output logic         resp_zero,
    output logic [3:0]   resp_lane_zero,
    output logic         busy,
    output logic [15:0]  ops_done
);

    localparam int unsigned PtrW = $clog2(RESP_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StIdle, StExec} state_e;

    state_e            state_q, state_d;
    logic [3:0]        wait_q, wait_d;
    logic              accept, push, pop;
    logic [PtrW-1:0]   wr_q, rd_q;
    logic [CntW-1:0]   count_q;
    logic [127:0]      res_mem  [RESP_DEPTH];
    logic              zero_mem [RESP_DEPTH];

    assign resp_valid = (count_q != '0);
    assign pop        = resp_valid && resp_ready;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        accept    = 1'b0;
        push      = 1'b0;
        req_ready = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Gating accept on free space guarantees the later push never overflows.
                req_ready = (count_q < CntW'(RESP_DEPTH));
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    wait_d  = 4'(ALU_LAT - 1);
                    state_d = StExec;
                end
            end
            StExec: begin
                busy = 1'b1;
                if (wait_q == 4'd0) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            alu_vec  <= 1'b0;
            wr_q     <= '0;
            rd_q     <= '0;
            count_q  <= '0;
            ops_done <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (accept) begin
                alu_a    <= req_a;
                alu_b    <= req_b;
                alu_ctrl <= req_ctrl;
                alu_vec  <= req_vec;
            end
            if (push) begin
                wr_q     <= wr_q + PtrW'(1);
                ops_done <= ops_done + 16'd1;
            end
            if (pop) begin
                rd_q <= rd_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_q]  <= alu_result;
            zero_mem[wr_q] <= alu_zero;
        end
    end

    assign resp_result = resp_valid ? res_mem[rd_q]  : '0;
    assign resp_zero   = resp_valid ? zero_mem[rd_q] : 1'b0;

`ifdef LANE_ZERO_EN
    logic [3:0] lane_zero;
    logic [3:0] lane_mem [RESP_DEPTH];

    always_comb begin
        lane_zero = '0;
        for (int i = 0; i < 4; i++) begin
            lane_zero[i] = (alu_result[32*i +: 32] == 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lane_mem[wr_q] <= lane_zero;
        end
    end

    assign resp_lane_zero = resp_valid ? lane_mem[rd_q] : 4'b0000;
`else
    assign resp_lane_zero = 4'b0000;
`endif

endmodule

// File: tb/tb_vector_alu_issue.sv
// Directed bench for vector_alu_issue: two instances (ALU_LAT=1 and ALU_LAT=3), each driven
// by a behavioural ALU model.
module tb_vector_alu_issue;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

`ifdef LANE_ZERO_EN
    localparam logic LzEn = 1'b1;
`else
    localparam logic LzEn = 1'b0;
`endif

    function automatic logic [127:0] alu_f(input logic [127:0] a, input logic [127:0] b,
                                           input logic [2:0] ctrl, input logic vec);
        logic [127:0] r;
        logic [31:0]  x, y, z;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            if (vec || i == 0) begin
                x = a[32*i +: 32];
                y = b[32*i +: 32];
                case (ctrl)
                    3'b000:  z = x + y;
                    3'b001:  z = x - y;
                    3'b010:  z = x & y;
                    3'b011:  z = x | y;
                    3'b100:  z = x ^ y;
                    3'b101:  z = x << y[4:0];
                    3'b110:  z = x >> y[4:0];
                    default: z = $unsigned($signed(x) >>> y[4:0]);
                endcase
                r[32*i +: 32] = z;
            end
        end
        return r;
    endfunction

    // Instance 1: ALU_LAT = 1
    logic         req_valid, req_ready, req_vec, alu_vec, alu_zero;
    logic [127:0] req_a, req_b, alu_a, alu_b, alu_result, resp_result;
    logic [2:0]   req_ctrl, alu_ctrl;
    logic         resp_valid, resp_ready, resp_zero, busy;
    logic [3:0]   resp_lane_zero;
    logic [15:0]  ops_done;

    assign alu_result = alu_f(alu_a, alu_b, alu_ctrl, alu_vec);
    assign alu_zero   = (alu_result[31:0] == 32'd0);

    vector_alu_issue #(.RESP_DEPTH(2), .ALU_LAT(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl), .req_vec(req_vec),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_vec(alu_vec),
        .alu_result(alu_result), .alu_zero(alu_zero), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_result(resp_result), .resp_zero(resp_zero),
        .resp_lane_zero(resp_lane_zero), .busy(busy), .ops_done(ops_done)
    );

    // Instance 3: ALU_LAT = 3
    logic         r3_valid, r3_ready, r3_vec, a3_vec, a3_zero;
    logic [127:0] r3_a, r3_b, a3_a, a3_b, a3_result, p3_result;
    logic [2:0]   r3_ctrl, a3_ctrl;
    logic         p3_valid, p3_ready, p3_zero, busy3;
    logic [3:0]   p3_lane_zero;
    logic [15:0]  ops3;

    assign a3_result = alu_f(a3_a, a3_b, a3_ctrl, a3_vec);
    assign a3_zero   = (a3_result[31:0] == 32'd0);

    vector_alu_issue #(.RESP_DEPTH(2), .ALU_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(r3_valid), .req_ready(r3_ready),
        .req_a(r3_a), .req_b(r3_b), .req_ctrl(r3_ctrl), .req_vec(r3_vec),
        .alu_a(a3_a), .alu_b(a3_b), .alu_ctrl(a3_ctrl), .alu_vec(a3_vec),
        .alu_result(a3_result), .alu_zero(a3_zero), .resp_valid(p3_valid),
        .resp_ready(p3_ready), .resp_result(p3_result), .resp_zero(p3_zero),
        .resp_lane_zero(p3_lane_zero), .busy(busy3), .ops_done(ops3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [127:0] a, input logic [127:0] b, input logic [2:0] c,
                           input logic v);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_ctrl  = c;
        req_vec   = v;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_ctrl = '0; req_vec = 1'b0;
        resp_ready = 1'b0;
        r3_valid = 1'b0; r3_a = '0; r3_b = '0; r3_ctrl = '0; r3_vec = 1'b0;
        p3_ready = 1'b0;
        step();
        step();
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_ops_done", ops_done, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_resp_result", resp_result, 0);
        reset = 1'b0;
        step();

        // ALU_LAT=3: srl 0x80 >> 3 = 0x10
        r3_valid = 1'b1; r3_a = 128'h80; r3_b = 128'h3; r3_ctrl = 3'b110;
        step();
        r3_valid = 1'b0; r3_a = '0;
        check("lat3_busy_c1", busy3, 1);
        check("lat3_alu_a_c1", a3_a, 128'h80);
        step();
        check("lat3_busy_c2", busy3, 1);
        check("lat3_valid_c2", p3_valid, 0);
        step();
        check("lat3_busy_c3", busy3, 1);
        check("lat3_alu_a_c3", a3_a, 128'h80);
        check("lat3_valid_c3", p3_valid, 0);
        step();
        check("lat3_busy_c4", busy3, 0);
        check("lat3_valid_c4", p3_valid, 1);
        check("lat3_result", p3_result, 128'h10);

        // Scalar add 5+7
        set_req(128'd5, 128'd7, 3'b000, 1'b0);
        step();
        req_valid = 1'b0;
        check("add_busy", busy, 1);
        check("add_req_ready_exec", req_ready, 0);
        check("add_valid_early", resp_valid, 0);
        step();
        check("add_valid", resp_valid, 1);
        check("add_result", resp_result, 128'd12);
        check("add_zero", resp_zero, 0);
        check("add_ops_done", ops_done, 1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("add_popped_valid", resp_valid, 0);
        check("add_popped_result", resp_result, 0);

        // Scalar sub to zero
        set_req(128'h1234, 128'h1234, 3'b001, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        check("sub_result", resp_result, 0);
        check("sub_zero", resp_zero, 1);
        check("sub_lane_zero", resp_lane_zero, LzEn ? 4'b1111 : 4'b0000);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Backpressure: three xors with resp_ready low
        set_req(128'h1, 128'h3, 3'b100, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        check("bp_ready_after1", req_ready, 1);
        set_req(128'hF0, 128'h0F, 3'b100, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        check("bp_ready_full", req_ready, 0);
        set_req(128'h8, 128'h1, 3'b100, 1'b0);
        step();
        step();
        check("bp_ready_held", req_ready, 0);
        check("bp_not_busy", busy, 0);
        check("bp_head1", resp_result, 128'h2);
        resp_ready = 1'b1;
        step();
        check("bp_head2_valid", resp_valid, 1);
        check("bp_head2", resp_result, 128'hFF);
        step();
        req_valid = 1'b0;
        check("bp_op3_busy", busy, 1);
        check("bp_empty", resp_valid, 0);
        step();
        check("bp_head3_valid", resp_valid, 1);
        check("bp_head3", resp_result, 128'h9);
        step();
        resp_ready = 1'b0;
        check("bp_drained", resp_valid, 0);
        check("bp_ops_done", ops_done, 5);

        // Simultaneous push and pop
        set_req(128'd10, 128'd20, 3'b000, 1'b0);
        step();
        req_valid = 1'b0;
        step();
        set_req(128'hFF, 128'h0F, 3'b010, 1'b0);
        step();
        req_valid = 1'b0;
        check("pp_head_old", resp_result, 128'h1E);
        resp_ready = 1'b1;
        step();
        check("pp_valid", resp_valid, 1);
        check("pp_head_new", resp_result, 128'h0F);
        step();
        resp_ready = 1'b0;
        check("pp_count_was_1", resp_valid, 0);
        check("pp_ops_done", ops_done, 7);

        // Vector add with lane wrap
        set_req({32'h1, 32'h0, 32'hFFFF_FFFF, 32'h2}, {32'h1, 32'h0, 32'h1, 32'h3},
                3'b000, 1'b1);
        step();
        req_valid = 1'b0;
        step();
        check("vec_result", resp_result, {32'h2, 32'h0, 32'h0, 32'h5});
        check("vec_zero", resp_zero, 0);
        check("vec_lane_zero", resp_lane_zero, LzEn ? 4'b0110 : 4'b0000);
        check("vec_ops_done", ops_done, 8);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;

        // Reset mid-EXEC
        set_req(128'd1, 128'd1, 3'b000, 1'b0);
        step();
        req_valid = 1'b0;
        check("rx_busy", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rx_valid", resp_valid, 0);
        check("rx_ops_done", ops_done, 0);
        check("rx_req_ready", req_ready, 1);
        check("rx_alu_a", alu_a, 0);
        check("rx_busy_clr", busy, 0);
        step();
        step();
        step();
        check("rx_no_stale", resp_valid, 0);
        check("rx_ops_still0", ops_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
